rr_mux_arbiter: RTL and testbench

- Four-requester round-robin arbiter that shares one DATA_W-wide 4:1 mux datapath between requesters.
- It owns the mux select and issues one-hot grants with a bounded hold time.
- It presents the granted requester's data on a single output bus.
- It sits between independent producers and a single downstream consumer, and is built from the team's existing 2:1 mux cell.

---
 rtl/rr_mux_arbiter_pkg.sv | 32 +++
 rtl/mux2_1.sv | 11 +
 rtl/rr_mux_arbiter_mux4_bus.sv | 39 +++
 rtl/rr_mux_arbiter.sv | 89 ++++++++
 tb/tb_rr_mux_arbiter.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
// Holds sizing constants, FSM encoding and the rotating-priority search.
package rr_mux_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;
  localparam int HOLD_W  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // First set request searching ptr, ptr+1, ptr+2, ptr+3 (mod NUM_REQ).
  // Iterating from the farthest offset down lets the nearest hit win.
  function automatic logic [SEL_W-1:0] rr_pick(
    input logic [NUM_REQ-1:0] req,
    input logic [SEL_W-1:0]   ptr
  );
    logic [SEL_W-1:0] idx;
    rr_pick = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr + SEL_W'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    onehot = NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux2_1.sv
// Existing single-bit 2:1 mux cell: y = sel ? y1 : y0.
module mux2_1 (
  input  logic sel,
  input  logic y0,
  input  logic y1,
  output logic y
);

  assign y = sel ? y1 : y0;

endmodule

// File: rtl/rr_mux_arbiter_mux4_bus.sv
// DATA_W-wide 4:1 mux assembled from mux2_1 cells, two levels per bit.
// sel[0] picks within each pair, sel[1] picks between the pairs.
module mux4_bus
  import rr_mux_arbiter_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [SEL_W-1:0]          sel,
  input  logic [NUM_REQ*DATA_W-1:0] din,
  output logic [DATA_W-1:0]         dout
);

  for (genvar b = 0; b < DATA_W; b++) begin : g_bit
    logic lo;
    logic hi;

    mux2_1 u_lo (
      .sel (sel[0]),
      .y0  (din[b]),
      .y1  (din[DATA_W + b]),
      .y   (lo)
    );

    mux2_1 u_hi (
      .sel (sel[0]),
      .y0  (din[2*DATA_W + b]),
      .y1  (din[3*DATA_W + b]),
      .y   (hi)
    );

    mux2_1 u_out (
      .sel (sel[1]),
      .y0  (lo),
      .y1  (hi),
      .y   (dout[b])
    );
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Four-requester round-robin arbiter owning a shared 4:1 data mux.
// Grants are one-hot, bounded to MAX_HOLD cycles, and separated by one idle cycle.
//
//   state | meaning
//   IDLE  | no owner; arbitrate live req from ptr, gnt = 0, sel holds last owner
//   GRANT | owner holds the mux; release on owner req low or hold limit
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] din,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      gnt_valid,
  output logic [SEL_W-1:0]          sel,
  output logic [DATA_W-1:0]         dout
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_e        state_q, state_d;
  logic [SEL_W-1:0]  owner_q, owner_d;
  logic [SEL_W-1:0]  ptr_q,   ptr_d;
  logic [HOLD_W-1:0] hold_q,  hold_d;
  logic [SEL_W-1:0]  winner;
  logic [DATA_W-1:0] mux_y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign winner = rr_pick(req, ptr_q);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          owner_d = winner;
          ptr_d   = winner + 1'b1;
          hold_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Non-owner requests are deliberately not looked at here.
        if (!req[owner_q] || hold_q == HOLD_LAST) begin
          state_d = IDLE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt_valid = (state_q == GRANT);
  assign gnt       = gnt_valid ? onehot(owner_q) : '0;
  assign sel       = owner_q;

  mux4_bus #(
    .DATA_W (DATA_W)
  ) u_mux (
    .sel  (owner_q),
    .din  (din),
    .dout (mux_y)
  );

  // Unregistered so dout tracks din within the cycle; gated to zero when idle.
  assign dout = gnt_valid ? mux_y : '0;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed, table-driven bench for rr_mux_arbiter (MAX_HOLD=4 and MAX_HOLD=1 instances).
module tb_rr_mux_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  req_h1;
  logic [31:0] din;

  logic [3:0]  gnt,  gnt_h1;
  logic        gnt_valid, gnt_valid_h1;
  logic [1:0]  sel,  sel_h1;
  logic [7:0]  dout, dout_h1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rr_mux_arbiter #(.DATA_W(8), .MAX_HOLD(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .din       (din),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .sel       (sel),
    .dout      (dout)
  );

  rr_mux_arbiter #(.DATA_W(8), .MAX_HOLD(1)) u_dut_h1 (
    .clk       (clk),
    .rst       (rst),
    .req       (req_h1),
    .din       (din),
    .gnt       (gnt_h1),
    .gnt_valid (gnt_valid_h1),
    .sel       (sel_h1),
    .dout      (dout_h1)
  );

  typedef struct {
    logic [3:0]  req;
    logic [31:0] din;
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic [7:0]  dout;
    logic [3:0]  gnt_h1;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] r, input logic [31:0] d, input logic [3:0] g,
                      input logic [1:0] s, input logic [7:0] o, input logic [3:0] g1);
    vec_t v;
    v.req = r; v.din = d; v.gnt = g; v.sel = s; v.dout = o; v.gnt_h1 = g1;
    tbl.push_back(v);
  endtask

  localparam logic [31:0] D0 = 32'h4433_2211;
  localparam logic [31:0] D1 = 32'h44A5_2211;

  initial begin
    logic [1:0] h1_sel_exp;
    logic [7:0] h1_dout_exp;
    string      tag;

    // saturation, req = 4'hF, MAX_HOLD=4 (h1 instance sees 4'b1001 throughout)
    push(4'hF, D0, 4'b0001, 2'd0, 8'h11, 4'b0001);
    push(4'hF, D0, 4'b0001, 2'd0, 8'h11, 4'b0000);
    push(4'hF, D0, 4'b0001, 2'd0, 8'h11, 4'b1000);
    push(4'hF, D0, 4'b0001, 2'd0, 8'h11, 4'b0000);
    push(4'hF, D0, 4'b0000, 2'd0, 8'h00, 4'b0001);
    push(4'hF, D0, 4'b0010, 2'd1, 8'h22, 4'b0000);
    push(4'hF, D0, 4'b0010, 2'd1, 8'h22, 4'b1000);
    push(4'hF, D0, 4'b0010, 2'd1, 8'h22, 4'b0000);
    push(4'hF, D0, 4'b0010, 2'd1, 8'h22, 4'b0001);
    push(4'hF, D0, 4'b0000, 2'd1, 8'h00, 4'b0000);
    push(4'hF, D0, 4'b0100, 2'd2, 8'h33, 4'b1000);
    push(4'hF, D0, 4'b0100, 2'd2, 8'h33, 4'b0000);
    push(4'hF, D0, 4'b0100, 2'd2, 8'h33, 4'b0001);
    push(4'hF, D0, 4'b0100, 2'd2, 8'h33, 4'b0000);
    push(4'hF, D0, 4'b0000, 2'd2, 8'h00, 4'b1000);
    push(4'hF, D0, 4'b1000, 2'd3, 8'h44, 4'b0000);
    push(4'hF, D0, 4'b1000, 2'd3, 8'h44, 4'b0001);
    push(4'hF, D0, 4'b1000, 2'd3, 8'h44, 4'b0000);
    push(4'hF, D0, 4'b1000, 2'd3, 8'h44, 4'b1000);
    push(4'hF, D0, 4'b0000, 2'd3, 8'h00, 4'b0000);
    push(4'hF, D0, 4'b0001, 2'd0, 8'h11, 4'b0001);
    // owner drops req: release, ptr now 1
    push(4'h0, D0, 4'b0000, 2'd0, 8'h00, 4'b0000);
    // single requester 2 for two cycles
    push(4'h4, D1, 4'b0100, 2'd2, 8'hA5, 4'b1000);
    push(4'h4, D1, 4'b0100, 2'd2, 8'hA5, 4'b0000);
    push(4'h0, D1, 4'b0000, 2'd2, 8'h00, 4'b0001);
    // pointer rotation: 3 granted/released, then 0 beats 1
    push(4'h8, D1, 4'b1000, 2'd3, 8'h44, 4'b0000);
    push(4'h0, D1, 4'b0000, 2'd3, 8'h00, 4'b1000);
    push(4'h3, D1, 4'b0001, 2'd0, 8'h11, 4'b0000);
    push(4'h2, D1, 4'b0000, 2'd0, 8'h00, 4'b0001);
    push(4'h2, D1, 4'b0010, 2'd1, 8'h22, 4'b0000);

    rst    = 1'b1;
    req    = 4'hF;
    req_h1 = 4'b1001;
    din    = D0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt",       32'(gnt),       32'h0);
    chk("rst_gnt_valid", 32'(gnt_valid), 32'h0);
    chk("rst_sel",       32'(sel),       32'h0);
    chk("rst_dout",      32'(dout),      32'h0);
    chk("rst_gnt_h1",    32'(gnt_h1),    32'h0);

    h1_sel_exp = 2'd0;
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      if (i == 0) rst = 1'b0;
      req = tbl[i].req;
      din = tbl[i].din;
      @(posedge clk);
      #1;
      if (tbl[i].gnt_h1 == 4'b0001) h1_sel_exp = 2'd0;
      if (tbl[i].gnt_h1 == 4'b1000) h1_sel_exp = 2'd3;
      h1_dout_exp = (tbl[i].gnt_h1 == 4'b0001) ? 8'h11 :
                    (tbl[i].gnt_h1 == 4'b1000) ? 8'h44 : 8'h00;
      tag = $sformatf("v%0d", i);
      chk({tag, "_gnt"},       32'(gnt),          32'(tbl[i].gnt));
      chk({tag, "_gnt_valid"}, 32'(gnt_valid),    32'(|tbl[i].gnt));
      chk({tag, "_sel"},       32'(sel),          32'(tbl[i].sel));
      chk({tag, "_dout"},      32'(dout),         32'(tbl[i].dout));
      chk({tag, "_h1_gnt"},    32'(gnt_h1),       32'(tbl[i].gnt_h1));
      chk({tag, "_h1_valid"},  32'(gnt_valid_h1), 32'(|tbl[i].gnt_h1));
      chk({tag, "_h1_sel"},    32'(sel_h1),       32'(h1_sel_exp));
      chk({tag, "_h1_dout"},   32'(dout_h1),      32'(h1_dout_exp));
    end

    // requester 1 owns the mux: a din change shows on dout without a clock edge
    #2;
    din[15:8] = 8'h77;
    #1;
    chk("comb_dout", 32'(dout), 32'h77);

    // asynchronous reset mid-tenure
    rst = 1'b1;
    #1;
    chk("async_rst_gnt",   32'(gnt),       32'h0);
    chk("async_rst_valid", 32'(gnt_valid), 32'h0);
    chk("async_rst_sel",   32'(sel),       32'h0);
    chk("async_rst_dout",  32'(dout),      32'h0);

    @(negedge clk);
    rst = 1'b0;
    req = 4'hF;
    @(posedge clk);
    #1;
    chk("post_rst_gnt", 32'(gnt), 32'h1);
    chk("post_rst_sel", 32'(sel), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
